// File: rtl/seq_fault_arbiter_if.sv
// Handshake and status bundle between the master sequencer and seq_fault_arbiter.
// The master modport drives enables, dones, VR faults and the clear request; the slave modport drives the failure lines and the fault record.
interface seq_fault_arbiter_if;
  logic [3:0] iEna;
  logic [3:0] iDone;
  logic [3:0] iVrFault;
  logic       iClrFault;
  logic [3:0] oFailure;
  logic       oFaultValid;
  logic [2:0] oFirstFaultCode;
  logic       oFirstFaultCause;
  logic       oMultiFault;

  modport master (
    output iEna, iDone, iVrFault, iClrFault,
    input  oFailure, oFaultValid, oFirstFaultCode, oFirstFaultCause, oMultiFault
  );

  modport slave (
    input  iEna, iDone, iVrFault, iClrFault,
    output oFailure, oFaultValid, oFirstFaultCode, oFirstFaultCause, oMultiFault
  );
endinterface

// File: rtl/seq_fault_arbiter.sv
// Supervises four sequencer handshakes and keeps a sticky first-fault record for the BMC.
// Define SEQ_FAULT_TIMEOUT_EN to add enable-to-done timeout detection in both directions.
module seq_fault_arbiter #(
  parameter int TIMEOUT_CYCLES = 400000,
  parameter int CNT_W          = 19
) (
  input logic                iClk,
  input logic                iRst,
  seq_fault_arbiter_if.slave bus
);

  typedef enum logic [2:0] {OFF, WAIT_UP, ON, WAIT_DN, FAULT} ChState;

  ChState     state     [4];
  ChState     nextState [4];
  logic [3:0] timeoutHit;
  logic [3:0] entryTimeout;
  logic [3:0] faultEntry;
  logic [3:0] failNext;
  logic [2:0] winCode;
  logic       winCause;
  logic       multiEntry;

  logic [3:0] failure;
  logic       faultValid;
  logic [2:0] firstCode;
  logic       firstCause;
  logic       multiFault;

`ifdef SEQ_FAULT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt [4];

  // Counter restarts on every state change; timeout fires on the edge that completes TIMEOUT_CYCLES waits.
  always_ff @(posedge iClk) begin
    for (int ch = 0; ch < 4; ch++) begin
      if (iRst || (nextState[ch] != state[ch])) begin
        cnt[ch] <= '0;
      end else if (((state[ch] == WAIT_UP) || (state[ch] == WAIT_DN)) && (cnt[ch] != CNT_MAX)) begin
        cnt[ch] <= cnt[ch] + 1'b1;
      end
    end
  end

  always_comb begin
    timeoutHit = '0;
    for (int ch = 0; ch < 4; ch++) begin
      timeoutHit[ch] = (cnt[ch] >= CNT_LAST);
    end
  end
`else
  localparam int unusedCfg = TIMEOUT_CYCLES + CNT_W;

  assign timeoutHit = '0;
`endif

  always_ff @(posedge iClk) begin
    for (int ch = 0; ch < 4; ch++) begin
      state[ch] <= iRst ? OFF : nextState[ch];
    end
  end

  // A VR fault outranks every handshake transition; done completion outranks a same-edge timeout.
  always_comb begin
    entryTimeout = '0;
    for (int ch = 0; ch < 4; ch++) begin
      nextState[ch] = state[ch];
      if ((state[ch] != FAULT) && bus.iVrFault[ch]) begin
        nextState[ch] = FAULT;
      end else begin
        case (state[ch])
          OFF: begin
            if (bus.iEna[ch]) nextState[ch] = WAIT_UP;
          end
          WAIT_UP: begin
            if (bus.iDone[ch]) begin
              nextState[ch] = ON;
            end else if (timeoutHit[ch]) begin
              nextState[ch]    = FAULT;
              entryTimeout[ch] = 1'b1;
            end else if (!bus.iEna[ch]) begin
              nextState[ch] = OFF;
            end
          end
          ON: begin
            if (!bus.iEna[ch]) nextState[ch] = WAIT_DN;
            else if (!bus.iDone[ch]) nextState[ch] = FAULT;
          end
          WAIT_DN: begin
            if (!bus.iDone[ch]) begin
              nextState[ch] = OFF;
            end else if (timeoutHit[ch]) begin
              nextState[ch]    = FAULT;
              entryTimeout[ch] = 1'b1;
            end else if (bus.iEna[ch]) begin
              nextState[ch] = ON;
            end
          end
          FAULT: begin
            if (bus.iClrFault && !bus.iEna[ch]) nextState[ch] = OFF;
          end
          default: nextState[ch] = OFF;
        endcase
      end
    end
  end

  // Walk from CPU_MEM down to BMC so the lowest-numbered entering channel is left as winner.
  always_comb begin
    failNext   = '0;
    faultEntry = '0;
    winCode    = 3'd0;
    winCause   = 1'b0;
    for (int ch = 3; ch >= 0; ch--) begin
      failNext[ch]   = (nextState[ch] == FAULT);
      faultEntry[ch] = (nextState[ch] == FAULT) && (state[ch] != FAULT);
      if ((nextState[ch] == FAULT) && (state[ch] != FAULT)) begin
        winCode  = 3'(ch + 1);
        winCause = entryTimeout[ch];
      end
    end
  end

  assign multiEntry = |(faultEntry & (faultEntry - 4'd1));

  // A fault entering on the clear edge is logged fresh rather than being wiped.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      failure    <= '0;
      faultValid <= 1'b0;
      firstCode  <= 3'd0;
      firstCause <= 1'b0;
      multiFault <= 1'b0;
    end else begin
      failure <= failNext;
      if (|faultEntry) begin
        if (!faultValid || bus.iClrFault) begin
          faultValid <= 1'b1;
          firstCode  <= winCode;
          firstCause <= winCause;
          multiFault <= multiEntry;
        end else begin
          multiFault <= 1'b1;
        end
      end else if (bus.iClrFault) begin
        faultValid <= 1'b0;
        firstCode  <= 3'd0;
        firstCause <= 1'b0;
        multiFault <= 1'b0;
      end
    end
  end

  assign bus.oFailure         = failure;
  assign bus.oFaultValid      = faultValid;
  assign bus.oFirstFaultCode  = firstCode;
  assign bus.oFirstFaultCause = firstCause;
  assign bus.oMultiFault      = multiFault;

endmodule

// File: tb/tb_seq_fault_arbiter.sv
// Bench for seq_fault_arbiter: directed vector table, timeout sequences and randomized traffic against a behavioural model.
// Expectations follow SEQ_FAULT_TIMEOUT_EN so the bench works with or without the timeout feature.
module tb_seq_fault_arbiter;

  localparam int T = 20;
`ifdef SEQ_FAULT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [3:0] ena;
    logic [3:0] done;
    logic [3:0] vr;
    logic       clr;
    logic [3:0] expFail;
    logic       expValid;
    logic [2:0] expCode;
    logic       expCause;
    logic       expMulti;
  } Vec;

  logic iClk;
  logic iRst;
  int   checks;
  int   failures;

  seq_fault_arbiter_if busIf ();

  seq_fault_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(19)) dut (
    .iClk(iClk),
    .iRst(iRst),
    .bus (busIf)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Model view of a channel: powered (up or draining), pending handshake with its age, and sticky failure.
  bit [3:0] mFailed;
  bit [3:0] mPow;
  bit [3:0] mPend;
  int       mAge [4];
  bit       mValid;
  bit [2:0] mCode;
  bit       mCause;
  bit       mMulti;

  task automatic modelStep();
    int ents[$];
    bit causes[$];
    if (iRst) begin
      mFailed = '0;
      mPow    = '0;
      mPend   = '0;
      for (int ch = 0; ch < 4; ch++) mAge[ch] = 0;
      mValid = 1'b0;
      mCode  = 3'd0;
      mCause = 1'b0;
      mMulti = 1'b0;
      return;
    end
    for (int ch = 0; ch < 4; ch++) begin
      bit e, d, v, target, goFault, why;
      e       = busIf.iEna[ch];
      d       = busIf.iDone[ch];
      v       = busIf.iVrFault[ch];
      goFault = 1'b0;
      why     = 1'b0;
      if (mFailed[ch]) begin
        if (busIf.iClrFault && !e) mFailed[ch] = 1'b0;
      end else if (v) begin
        goFault = 1'b1;
      end else if (mPend[ch]) begin
        target = !mPow[ch];
        if (d == target) begin
          mPow[ch]  = target;
          mPend[ch] = 1'b0;
        end else if (TO_EN && (mAge[ch] + 1 >= T)) begin
          goFault = 1'b1;
          why     = 1'b1;
        end else if (e != target) begin
          mPend[ch] = 1'b0;
        end else begin
          mAge[ch]++;
        end
      end else if (!mPow[ch]) begin
        if (e) begin
          mPend[ch] = 1'b1;
          mAge[ch]  = 0;
        end
      end else if (!e) begin
        mPend[ch] = 1'b1;
        mAge[ch]  = 0;
      end else if (!d) begin
        goFault = 1'b1;
      end
      if (goFault) begin
        mFailed[ch] = 1'b1;
        mPow[ch]    = 1'b0;
        mPend[ch]   = 1'b0;
        ents.push_back(ch);
        causes.push_back(why);
      end
    end
    if (ents.size() > 0) begin
      if (!mValid || busIf.iClrFault) begin
        mValid = 1'b1;
        mCode  = 3'(ents[0] + 1);
        mCause = causes[0];
        mMulti = (ents.size() > 1);
      end else begin
        mMulti = 1'b1;
      end
    end else if (busIf.iClrFault) begin
      mValid = 1'b0;
      mCode  = 3'd0;
      mCause = 1'b0;
      mMulti = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] ena, input logic [3:0] done,
                               input logic [3:0] vr, input logic clr);
    iRst            = rst;
    busIf.iEna      = ena;
    busIf.iDone     = done;
    busIf.iVrFault  = vr;
    busIf.iClrFault = clr;
    @(posedge iClk);
    modelStep();
    #1;
  endtask

  task automatic compare(input string what, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", what, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eFail, input logic eValid,
                             input logic [2:0] eCode, input logic eCause, input logic eMulti);
    compare({name, ".failure"}, busIf.oFailure, eFail);
    compare({name, ".valid"}, {3'b0, busIf.oFaultValid}, {3'b0, eValid});
    compare({name, ".code"}, {1'b0, busIf.oFirstFaultCode}, {1'b0, eCode});
    compare({name, ".cause"}, {3'b0, busIf.oFirstFaultCause}, {3'b0, eCause});
    compare({name, ".multi"}, {3'b0, busIf.oMultiFault}, {3'b0, eMulti});
  endtask

  Vec       vecs [15];
  bit [3:0] lazy;
  logic [3:0] rEna, rDone, rVr;

  initial begin
    checks          = 0;
    failures        = 0;
    iRst            = 1'b1;
    busIf.iEna      = '0;
    busIf.iDone     = '0;
    busIf.iVrFault  = '0;
    busIf.iClrFault = 1'b0;

    // rst, ena, done, vr, clr | failure, valid, code, cause, multi
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0001, 4'b0001, 4'b1010, 1'b0, 4'b1010, 1'b1, 3'd2, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'b1001, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b1001, 4'b1001, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'b1001, 4'b0001, 4'b0000, 1'b0, 4'b1000, 1'b1, 3'd4, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b1001, 4'b0001, 4'b0000, 1'b1, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'b0001, 4'b0000, 4'b0100, 1'b0, 4'b0101, 1'b1, 3'd1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 4'b0001, 4'b0000, 4'b0010, 1'b1, 4'b0011, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ena, vecs[i].done, vecs[i].vr, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].expFail, vecs[i].expValid,
                  vecs[i].expCode, vecs[i].expCause, vecs[i].expMulti);
    end

    // BMC powers up with done arriving after 10 cycles.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    checkOutput("bmcUp", 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);

    // PSU_MAIN power-up timeout: fault exactly T edges after WAIT_UP entry.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    for (int j = 1; j < T; j++) begin
      applyStimulus(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
      compare($sformatf("upWait%0d.failure", j), busIf.oFailure, 4'b0000);
    end
    applyStimulus(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    checkOutput("upTimeout", TO_EN ? 4'b0100 : 4'b0000, TO_EN, TO_EN ? 3'd3 : 3'd0, TO_EN, 1'b0);

    // Done sampled on the timeout edge wins.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    for (int j = 1; j < T; j++) applyStimulus(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0);
    checkOutput("upLastEdge", 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) applyStimulus(1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b0);
    checkOutput("upHeld", 4'b0000, 1'b0, 3'd0, 1'b0, 1'b0);

    // PCH power-down timeout with done stuck high.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    for (int j = 1; j < T; j++) begin
      applyStimulus(1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0);
      compare($sformatf("dnWait%0d.failure", j), busIf.oFailure, 4'b0000);
    end
    applyStimulus(1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    checkOutput("dnTimeout", TO_EN ? 4'b0010 : 4'b0000, TO_EN, TO_EN ? 3'd2 : 3'd0, TO_EN, 1'b0);
    for (int j = 0; j < 5; j++) applyStimulus(1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    checkOutput("dnLater", TO_EN ? 4'b0010 : 4'b0000, TO_EN, TO_EN ? 3'd2 : 3'd0, TO_EN, 1'b0);

    // Randomized traffic; lazy channels stop answering for a while to provoke timeouts.
    applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    checkOutput("rndReset", mFailed, mValid, mCode, mCause, mMulti);
    lazy  = '0;
    rEna  = '0;
    rDone = '0;
    for (int i = 0; i < 4000; i++) begin
      for (int ch = 0; ch < 4; ch++) begin
        if ($urandom_range(63) == 0) lazy[ch] = ~lazy[ch];
        if ($urandom_range(15) == 0) rEna[ch] = ~rEna[ch];
        if (!lazy[ch] && ($urandom_range(31) < 6)) rDone[ch] = rEna[ch];
        else if ($urandom_range(63) == 0) rDone[ch] = ~rDone[ch];
        rVr[ch] = ($urandom_range(127) == 0);
      end
      applyStimulus($urandom_range(499) == 0, rEna, rDone, rVr, $urandom_range(15) == 0);
      checkOutput($sformatf("rnd%0d", i), mFailed, mValid, mCode, mCause, mMulti);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_fault_arbiter.md
# seq_fault_arbiter

Supervises the four power sequencers (BMC, PCH, PSU_MAIN, CPU_MEM) on behalf of the master sequencer. Per channel, tracks the enable/done handshake, flags VR faults and enable-to-done timeouts in both power-up and power-down directions, and drives the per-sequencer failure lines the master consumes. Arbitrates simultaneous faults into one sticky first-fault record readable by the BMC and cleared only on explicit request.

## Interface
- TIMEOUT_CYCLES, 400000: handshake timeout in iClk cycles (200 ms at 2 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 19: timeout counter width.
- iClk  in  1  system clock (2 MHz).
- iRst  in  1  synchronous, active-high reset.
- iEna  in  4  sequencer enables from the master; bit0 BMC, bit1 PCH, bit2 PSU_MAIN, bit3 CPU_MEM.
- iDone  in  4  sequencer done indications, same bit order.
- iVrFault  in  4  raw VR fault reports from each sequencer, level, active high.
- iClrFault  in  1  single-cycle clear request for fault record and sticky failures.
- oFailure  out  4  per-channel failure to master, sticky, same bit order.
- oFaultValid  out  1  first-fault record holds a fault.
- oFirstFaultCode  out  3  0 none, 1 BMC, 2 PCH, 3 PSU_MAIN, 4 CPU_MEM.
- oFirstFaultCause  out  1  0 VR fault, 1 handshake timeout.
- oMultiFault  out  1  at least one further fault occurred after the first was logged.

## Operation
- Per-channel FSM, states OFF, WAIT_UP, ON, WAIT_DN, FAULT; reset state OFF.
- OFF: iEna=1 -> WAIT_UP, counter=0.
- WAIT_UP: iDone=1 -> ON; counter reaches TIMEOUT_CYCLES -> FAULT (cause timeout); iEna=0 with iDone=0 -> OFF (aborted power-up, no fault).
- ON: iEna=0 -> WAIT_DN, counter=0; iDone=0 while iEna=1 -> FAULT (cause VR fault, unexpected done drop).
- WAIT_DN: iDone=0 -> OFF; counter reaches TIMEOUT_CYCLES -> FAULT (cause timeout); iEna=1 -> ON (re-enable before done drops).
- Any state except FAULT: iVrFault=1 -> FAULT (cause VR fault); VR fault outranks every other transition that cycle.
- FAULT: oFailure[ch]=1. Exits to OFF only when iClrFault=1 and iEna[ch]=0 in the same cycle; otherwise holds.
- Counter increments once per cycle in WAIT_UP/WAIT_DN, saturates at TIMEOUT_CYCLES, cleared on every state entry.
- Arbitration: faults entering FAULT on the same edge resolved by fixed priority, lowest bit wins (BMC highest). Winner logged only if oFaultValid=0; any other fault entry (simultaneous loser or later) sets oMultiFault.
- iClrFault clears oFaultValid, oFirstFaultCode, oFirstFaultCause, oMultiFault unconditionally; a fault entering FAULT on the same edge wins over clear and is logged fresh.

## Timing
- Reset: all FSMs OFF, counters 0, all outputs 0.
- All outputs registered; oFailure and record update on the edge the FSM enters FAULT.
- VR fault: iVrFault sampled high at edge k -> oFailure high after edge k (1-cycle latency).
- Timeout: FSM enters WAIT state at edge k; iDone transition sampled at edges k+1..k+TIMEOUT_CYCLES completes the handshake; iDone sampled at k+TIMEOUT_CYCLES wins over timeout; FAULT entered at edge k+TIMEOUT_CYCLES only if iDone still unchanged.
- Reset asserted mid-operation: everything returns to reset values on that edge regardless of state; inputs ignored while iRst=1.

## Configuration
- SEQ_FAULT_TIMEOUT_EN defined: timeout counters and timeout transitions present as above.
- Undefined: no counters; WAIT states wait indefinitely; only VR faults and unexpected done drop reach FAULT; oFirstFaultCause tied 0; TIMEOUT_CYCLES/CNT_W unused.

## Test plan
- Reset, then iEna=0001, iDone[0]=1 after 10 cycles -> channel 0 ON, oFailure=0000, oFaultValid=0.
- TIMEOUT_CYCLES=20, iEna[2]=1, iDone[2] held 0 -> oFailure=0100 exactly 20 cycles after WAIT_UP entry, code=3, cause=1; iDone[2] rising at cycle 20 -> no fault.
- iVrFault=1010 on one edge -> oFailure=1010 next cycle, code=2 (PCH), cause=0, oMultiFault=1.
- Channel 3 ON, iDone[3] drops with iEna[3]=1 -> oFailure[3]=1, code=4, cause=0; iClrFault with iEna[3]=1 -> record cleared, oFailure[3] stays 1; iClrFault with iEna[3]=0 -> oFailure[3]=0, FSM OFF.
- iEna[1] 1->0 from ON, iDone[1] held 1 for TIMEOUT_CYCLES -> oFailure[1]=1, cause=1; repeat with SEQ_FAULT_TIMEOUT_EN undefined -> no fault.
- iRst pulse while two channels in FAULT and record valid -> all outputs 0 next cycle.
